// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline controller: stall/flush/cause/issue-mode
// values, the exception entry vector and the redirect FSM states.
package pipe_ctrl_pkg;

  localparam logic STOP         = 1'b1;
  localparam logic NO_STOP      = 1'b0;
  localparam logic FLUSH        = 1'b1;
  localparam logic NO_FLUSH     = 1'b0;
  localparam logic CAUSE_EXC    = 1'b0;
  localparam logic CAUSE_BP     = 1'b1;
  localparam logic DUAL_ISSUE   = 1'b0;
  localparam logic SINGLE_ISSUE = 1'b1;

  localparam logic [31:0] EXC_VECTOR = 32'hBFC00380;

  localparam int PIPE_CTRL_STATE_W = 2;

  typedef enum logic [PIPE_CTRL_STATE_W-1:0] {
    ST_RUN     = 2'd0,
    ST_BR_PEND = 2'd1,
    ST_DS_WAIT = 2'd2
  } pipe_ctrl_state_e;

  // Returns {stall_pc, stall[3:0]}; the most downstream requester wins.
  function automatic logic [4:0] stall_chain(input logic req_mem, input logic req_ex,
                                             input logic req_id, input logic req_if);
    logic [4:0] res;
    if (req_mem) begin
      res = {STOP, NO_STOP, STOP, STOP, STOP};
    end else if (req_ex) begin
      res = {STOP, NO_STOP, NO_STOP, STOP, STOP};
    end else if (req_id) begin
      res = {STOP, NO_STOP, NO_STOP, NO_STOP, STOP};
    end else if (req_if) begin
      res = {STOP, NO_STOP, NO_STOP, NO_STOP, NO_STOP};
    end else begin
      res = 5'b00000;
    end
    return res;
  endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline controller: combinational stall chain, exception redirect and
// sequencing of branch-mispredict redirects that must wait for MEM or the delay slot.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if_i,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        stallreq_mem_i,
  input  logic        exc_valid_i,
  input  logic        exc_is_eret_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        bp_fail_i,
  input  logic [31:0] bp_target_i,
  input  logic        bp_issue_mode_i,
  input  logic        ds_issued_i,
  output logic        stall_pc_o,
  output logic [3:0]  stall_o,
  output logic        flush_o,
  output logic        flush_cause_o,
  output logic        ex_issue_mode_o,
  output logic [31:0] new_pc_o
);

  pipe_ctrl_state_e state_r;
  logic [31:0]      tgt_r;
  logic             mode_r;
  logic [4:0]       chain_s;

  assign chain_s = stall_chain(stallreq_mem_i, stallreq_ex_i, stallreq_id_i, stallreq_if_i);

  // Redirect FSM and latched mispredict target/mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_RUN;
      tgt_r   <= 32'h0000_0000;
      mode_r  <= DUAL_ISSUE;
    end else if (exc_valid_i) begin
      state_r <= ST_RUN;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (bp_fail_i && stallreq_mem_i) begin
            state_r <= ST_BR_PEND;
            tgt_r   <= bp_target_i;
            mode_r  <= bp_issue_mode_i;
          end else if (bp_fail_i && !ds_issued_i) begin
            state_r <= ST_DS_WAIT;
            tgt_r   <= bp_target_i;
            mode_r  <= bp_issue_mode_i;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_BR_PEND: begin
          if (stallreq_mem_i) begin
            state_r <= ST_BR_PEND;
          end else if (ds_issued_i) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_DS_WAIT;
          end
        end
        ST_DS_WAIT: begin
          if (ds_issued_i) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_DS_WAIT;
          end
        end
        default: state_r <= ST_RUN;
      endcase
    end
  end

  // Output decode: exception beats mispredict flush, which beats the stall chain.
  always_comb begin
    stall_pc_o      = chain_s[4];
    stall_o         = chain_s[3:0];
    flush_o         = NO_FLUSH;
    flush_cause_o   = CAUSE_EXC;
    ex_issue_mode_o = DUAL_ISSUE;
    new_pc_o        = 32'h0000_0000;
    if (exc_valid_i) begin
      stall_pc_o = NO_STOP;
      stall_o    = 4'b0000;
      flush_o    = FLUSH;
      new_pc_o   = exc_is_eret_i ? cp0_epc_i : EXC_VECTOR;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (bp_fail_i && !stallreq_mem_i && ds_issued_i) begin
            stall_pc_o      = NO_STOP;
            stall_o         = 4'b0000;
            flush_o         = FLUSH;
            flush_cause_o   = CAUSE_BP;
            ex_issue_mode_o = bp_issue_mode_i;
            new_pc_o        = bp_target_i;
          end else begin
            flush_o = NO_FLUSH;
          end
        end
        ST_BR_PEND: begin
          if (!stallreq_mem_i && ds_issued_i) begin
            stall_pc_o      = NO_STOP;
            stall_o         = 4'b0000;
            flush_o         = FLUSH;
            flush_cause_o   = CAUSE_BP;
            ex_issue_mode_o = mode_r;
            new_pc_o        = tgt_r;
          end else begin
            flush_o = NO_FLUSH;
          end
        end
        ST_DS_WAIT: begin
          // Only the delay slot survives, so the redirect is always single-issue.
          if (ds_issued_i) begin
            stall_pc_o      = NO_STOP;
            stall_o         = 4'b0000;
            flush_o         = FLUSH;
            flush_cause_o   = CAUSE_BP;
            ex_issue_mode_o = SINGLE_ISSUE;
            new_pc_o        = tgt_r;
          end else begin
            flush_o = NO_FLUSH;
          end
        end
        default: flush_o = NO_FLUSH;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: each driven cycle pushes its expected
// outputs, which the negedge monitor pops and compares.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i;
  logic        exc_valid_i, exc_is_eret_i;
  logic [31:0] cp0_epc_i;
  logic        bp_fail_i;
  logic [31:0] bp_target_i;
  logic        bp_issue_mode_i;
  logic        ds_issued_i;
  logic        stall_pc_o;
  logic [3:0]  stall_o;
  logic        flush_o, flush_cause_o, ex_issue_mode_o;
  logic [31:0] new_pc_o;

  typedef struct packed {
    logic [3:0]  stall;
    logic        spc;
    logic        flush;
    logic        cause;
    logic        mode;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   checks_cnt = 0;
  int   errors_cnt = 0;

  pipe_ctrl dut (
    .clk(clk), .rst(rst),
    .stallreq_if_i(stallreq_if_i), .stallreq_id_i(stallreq_id_i),
    .stallreq_ex_i(stallreq_ex_i), .stallreq_mem_i(stallreq_mem_i),
    .exc_valid_i(exc_valid_i), .exc_is_eret_i(exc_is_eret_i), .cp0_epc_i(cp0_epc_i),
    .bp_fail_i(bp_fail_i), .bp_target_i(bp_target_i), .bp_issue_mode_i(bp_issue_mode_i),
    .ds_issued_i(ds_issued_i),
    .stall_pc_o(stall_pc_o), .stall_o(stall_o), .flush_o(flush_o),
    .flush_cause_o(flush_cause_o), .ex_issue_mode_o(ex_issue_mode_o), .new_pc_o(new_pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks_cnt++;
    if (obs !== exp_v) begin
      errors_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Compare the DUT against the oldest expected entry mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_eq("stall",      {28'h0, stall_o},         {28'h0, e.stall});
      check_eq("stall_pc",   {31'h0, stall_pc_o},      {31'h0, e.spc});
      check_eq("flush",      {31'h0, flush_o},         {31'h0, e.flush});
      check_eq("cause",      {31'h0, flush_cause_o},   {31'h0, e.cause});
      check_eq("issue_mode", {31'h0, ex_issue_mode_o}, {31'h0, e.mode});
      check_eq("new_pc",     new_pc_o,                 e.pc);
    end
  end

  // req = {mem, ex, id, if}
  task automatic step(input logic [3:0] req, input logic exc, input logic eret,
                      input logic [31:0] epc, input logic bpf, input logic [31:0] tgt,
                      input logic bmode, input logic ds,
                      input logic [3:0] e_stall, input logic e_spc, input logic e_flush,
                      input logic e_cause, input logic e_mode, input logic [31:0] e_pc);
    exp_t e;
    @(posedge clk);
    #1;
    {stallreq_mem_i, stallreq_ex_i, stallreq_id_i, stallreq_if_i} = req;
    exc_valid_i     = exc;
    exc_is_eret_i   = eret;
    cp0_epc_i       = epc;
    bp_fail_i       = bpf;
    bp_target_i     = tgt;
    bp_issue_mode_i = bmode;
    ds_issued_i     = ds;
    e = '{stall: e_stall, spc: e_spc, flush: e_flush, cause: e_cause, mode: e_mode, pc: e_pc};
    exp_q.push_back(e);
  endtask

  task automatic idle_step(input logic ds);
    step(4'b0000, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, ds,
         4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic clear_inputs();
    {stallreq_mem_i, stallreq_ex_i, stallreq_id_i, stallreq_if_i} = 4'b0000;
    exc_valid_i = 1'b0; exc_is_eret_i = 1'b0; cp0_epc_i = 32'h0;
    bp_fail_i = 1'b0; bp_target_i = 32'h0; bp_issue_mode_i = 1'b0; ds_issued_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_stall"},    {28'h0, stall_o},         32'h0);
    check_eq({tag, "_stall_pc"}, {31'h0, stall_pc_o},      32'h0);
    check_eq({tag, "_flush"},    {31'h0, flush_o},         32'h0);
    check_eq({tag, "_cause"},    {31'h0, flush_cause_o},   32'h0);
    check_eq({tag, "_mode"},     {31'h0, ex_issue_mode_o}, 32'h0);
    check_eq({tag, "_new_pc"},   new_pc_o,                 32'h0);
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Stall chain
    idle_step(1'b0);
    step(4'b1010, 0, 0, 32'h0, 0, 32'h0, 0, 0, 4'b0111, 1, 0, 0, 0, 32'h0);
    step(4'b0100, 0, 0, 32'h0, 0, 32'h0, 0, 0, 4'b0011, 1, 0, 0, 0, 32'h0);
    step(4'b0010, 0, 0, 32'h0, 0, 32'h0, 0, 0, 4'b0001, 1, 0, 0, 0, 32'h0);
    step(4'b0001, 0, 0, 32'h0, 0, 32'h0, 0, 0, 4'b0000, 1, 0, 0, 0, 32'h0);
    step(4'b0101, 0, 0, 32'h0, 0, 32'h0, 0, 0, 4'b0011, 1, 0, 0, 0, 32'h0);

    // Exceptions during an EX stall
    step(4'b0100, 1, 0, 32'h80001234, 0, 32'h0, 0, 0, 4'b0000, 0, 1, 0, 0, 32'hBFC00380);
    step(4'b0100, 1, 1, 32'h80001234, 0, 32'h0, 0, 0, 4'b0000, 0, 1, 0, 0, 32'h80001234);

    // Direct mispredict, both issue modes
    step(4'b0000, 0, 0, 32'h0, 1, 32'h80000040, 0, 1, 4'b0000, 0, 1, 1, 0, 32'h80000040);
    idle_step(1'b1);
    step(4'b0011, 0, 0, 32'h0, 1, 32'h80000080, 1, 1, 4'b0000, 0, 1, 1, 1, 32'h80000080);
    idle_step(1'b1);

    // BR_PEND: mem held 3 cycles, stray bp_fail ignored, flush on release
    step(4'b1000, 0, 0, 32'h0, 1, 32'h80000100, 1, 1, 4'b0111, 1, 0, 0, 0, 32'h0);
    step(4'b1000, 0, 0, 32'h0, 1, 32'hDEAD0000, 0, 1, 4'b0111, 1, 0, 0, 0, 32'h0);
    step(4'b1000, 0, 0, 32'h0, 0, 32'h0, 0, 1, 4'b0111, 1, 0, 0, 0, 32'h0);
    step(4'b0000, 0, 0, 32'h0, 0, 32'h0, 0, 1, 4'b0000, 0, 1, 1, 1, 32'h80000100);
    idle_step(1'b1);

    // BR_PEND -> DS_WAIT -> flush as single issue
    step(4'b1000, 0, 0, 32'h0, 1, 32'h80000200, 0, 0, 4'b0111, 1, 0, 0, 0, 32'h0);
    idle_step(1'b0);
    step(4'b0000, 0, 0, 32'h0, 0, 32'h0, 0, 1, 4'b0000, 0, 1, 1, 1, 32'h80000200);
    idle_step(1'b1);

    // DS_WAIT direct: stall chain works meanwhile; flush overrides if/id stalls
    step(4'b0000, 0, 0, 32'h0, 1, 32'h80000300, 0, 0, 4'b0000, 0, 0, 0, 0, 32'h0);
    step(4'b0010, 0, 0, 32'h0, 0, 32'h0, 0, 0, 4'b0001, 1, 0, 0, 0, 32'h0);
    step(4'b0011, 0, 0, 32'h0, 0, 32'h0, 0, 1, 4'b0000, 0, 1, 1, 1, 32'h80000300);
    idle_step(1'b1);

    // Exception in DS_WAIT discards the pending redirect
    step(4'b0000, 0, 0, 32'h0, 1, 32'h80000400, 0, 0, 4'b0000, 0, 0, 0, 0, 32'h0);
    step(4'b0000, 1, 0, 32'h0, 0, 32'h0, 0, 0, 4'b0000, 0, 1, 0, 0, 32'hBFC00380);
    idle_step(1'b1);
    idle_step(1'b1);

    // Exception and bp_fail together: branch not latched
    step(4'b0000, 1, 0, 32'h0, 1, 32'h80000500, 1, 0, 4'b0000, 0, 1, 0, 0, 32'hBFC00380);
    idle_step(1'b1);

    // Asynchronous reset while in BR_PEND
    step(4'b1000, 0, 0, 32'h0, 1, 32'h80000600, 1, 1, 4'b0111, 1, 0, 0, 0, 32'h0);
    @(posedge clk);
    #1;
    clear_inputs();
    ds_issued_i = 1'b1;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    idle_step(1'b1);
    idle_step(1'b1);

    @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("queue_drained", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
